// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Latency: none; declarations only.
// Backpressure: not applicable.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int GAP_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO, first-word-fall-through: dout shows the head whenever not empty.
// Latency: a push is visible on dout/level one edge after it is sampled.
// Backpressure: push while full and pop while empty are ignored; the caller flags drops.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [UART_DATA_W-1:0] din,
    output logic [UART_DATA_W-1:0] dout,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            level
);

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]          rdPtr;
    logic [AW-1:0]          wrPtr;
    logic                   doPush;
    logic                   doPop;

    // The occupancy count alone decides full/empty; pointers just wrap modulo DEPTH.
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign full   = (level == (AW + 1)'(DEPTH));
    assign empty  = (level == '0);
    assign dout   = mem[rdPtr];

    // Storage, pointers and occupancy; reset empties the buffer completely.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem[wrPtr] <= din;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (doPush && !doPop) begin
                level <= level + 1'b1;
            end else if (doPop && !doPush) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_xmit_feeder.sv
// Buffers host bytes and launches them one at a time into the UART transmitter.
// Latency: byte written into an idle, empty feeder launches one cycle after it is stored.
// Backpressure: writes while full are dropped with a one-cycle overflow pulse; launches wait for xmit_doneH plus GAP_CYCLES.
module uart_xmit_feeder
    import uart_pkg::*;
#(
    parameter  int DEPTH      = 16,
    parameter  int GAP_CYCLES = 0,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            level,
    output logic                   overflow,
    output logic                   xmitH,
    output logic [UART_DATA_W-1:0] xmit_dataH,
    input  logic                   xmit_doneH
);

    feeder_state_t          state;
    logic [GAP_W-1:0]       gapCnt;
    logic                   fifoPop;
    logic [UART_DATA_W-1:0] fifoHead;

    // The head leaves the FIFO in exactly the cycle the sequencer launches it.
    assign fifoPop = (state == IDLE) && !empty;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .push    (wr_en),
        .pop     (fifoPop),
        .din     (wr_data),
        .dout    (fifoHead),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // Flag a write that arrived while full; the FIFO has already refused it.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full;
        end
    end

    // Launch sequencer: one frame in flight, then an optional idle gap before the next launch.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            gapCnt     <= '0;
            xmitH      <= 1'b0;
            xmit_dataH <= '0;
        end else begin
            xmitH <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        xmit_dataH <= fifoHead;
                        xmitH      <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // A done coinciding with our own strobe cannot belong to this frame.
                    if (xmit_doneH && !xmitH) begin
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            gapCnt <= GAP_W'(GAP_CYCLES);
                            state  <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gapCnt <= GAP_W'(1)) begin
                        gapCnt <= '0;
                        state  <= IDLE;
                    end else begin
                        gapCnt <= gapCnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_xmit_feeder.sv
// Bench for uart_xmit_feeder: two instances (16 deep / no gap, 4 deep / gap of 2).
// Stimulus queues expected launches; a monitor pops them as xmitH appears.
// A small UART model answers launches with xmit_doneH on request or after a delay.
module tb_uart_xmit_feeder;

    localparam int D0 = 16;
    localparam int G0 = 0;
    localparam int D1 = 4;
    localparam int G1 = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       wrEn     [2];
    logic [7:0] wrData   [2];
    logic       doneH    [2];
    logic       full     [2];
    logic       empty    [2];
    logic       overflow [2];
    logic       xmitH    [2];
    logic [7:0] xmitData [2];
    logic [4:0] lvl0;
    logic [2:0] lvl1;

    int checks = 0;
    int errors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    bit autoDone [2];
    bit randDly  [2];
    bit chkGap   [2];
    int fixDly   [2];
    int pulseReq [2];
    int pulseAck [2];
    int cntdn    [2];

    int cyc;
    int doneEdge [2];
    bit inFlight [2];
    bit prevX    [2];

    always #5 sys_clk = ~sys_clk;

    uart_xmit_feeder #(.DEPTH(D0), .GAP_CYCLES(G0)) u0 (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .wr_en      (wrEn[0]),
        .wr_data    (wrData[0]),
        .full       (full[0]),
        .empty      (empty[0]),
        .level      (lvl0),
        .overflow   (overflow[0]),
        .xmitH      (xmitH[0]),
        .xmit_dataH (xmitData[0]),
        .xmit_doneH (doneH[0])
    );

    uart_xmit_feeder #(.DEPTH(D1), .GAP_CYCLES(G1)) u1 (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .wr_en      (wrEn[1]),
        .wr_data    (wrData[1]),
        .full       (full[1]),
        .empty      (empty[1]),
        .level      (lvl1),
        .overflow   (overflow[1]),
        .xmitH      (xmitH[1]),
        .xmit_dataH (xmitData[1]),
        .xmit_doneH (doneH[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic nedge(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulseDone(input int i);
        pulseReq[i]++;
    endtask

    task automatic chkReset(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_xmitH%0d", tag, i), int'(xmitH[i]), 0);
            chk($sformatf("%s_data%0d", tag, i), int'(xmitData[i]), 0);
            chk($sformatf("%s_full%0d", tag, i), int'(full[i]), 0);
            chk($sformatf("%s_empty%0d", tag, i), int'(empty[i]), 1);
            chk($sformatf("%s_ovf%0d", tag, i), int'(overflow[i]), 0);
        end
        chk({tag, "_lvl0"}, int'(lvl0), 0);
        chk({tag, "_lvl1"}, int'(lvl1), 0);
    endtask

    task automatic waitDrain(input int i, input int budget);
        int n = 0;
        while (((i == 0) ? q0.size() : q1.size()) != 0 && n < budget) begin
            nedge(1);
            n++;
        end
        chk($sformatf("drain%0d", i), (i == 0) ? q0.size() : q1.size(), 0);
    endtask

    // Forget the last done so a launch after an idle spell is not timed against it.
    task automatic clearGap(input int i);
        chkGap[i] = 1'b0;
        nedge(2);
        chkGap[i] = 1'b1;
    endtask

    // UART model: drives done just after each falling edge.
    initial begin
        for (int i = 0; i < 2; i++) begin
            doneH[i]    = 1'b0;
            pulseAck[i] = 0;
            cntdn[i]    = 0;
        end
        forever begin
            @(negedge sys_clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                doneH[i] = 1'b0;
                if (sys_rst) begin
                    cntdn[i] = 0;
                end else if (xmitH[i] && autoDone[i]) begin
                    cntdn[i] = randDly[i] ? int'($urandom_range(6, 1)) : fixDly[i];
                end else if (cntdn[i] > 0) begin
                    cntdn[i]--;
                    if (cntdn[i] == 0) doneH[i] = 1'b1;
                end
                if (pulseReq[i] != pulseAck[i]) begin
                    doneH[i] = 1'b1;
                    pulseAck[i]++;
                end
            end
        end
    end

    // Monitor: checks launch data order, one frame in flight, and done-to-launch spacing.
    initial begin
        bit         have;
        logic [7:0] expB;
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            doneEdge[i] = -1;
            inFlight[i] = 1'b0;
            prevX[i]    = 1'b0;
        end
        forever begin
            @(negedge sys_clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (sys_rst) begin
                    inFlight[i] = 1'b0;
                    prevX[i]    = 1'b0;
                    doneEdge[i] = -1;
                    if (i == 0) q0.delete();
                    else q1.delete();
                end else begin
                    if (doneH[i] && inFlight[i] && !prevX[i]) begin
                        inFlight[i] = 1'b0;
                        doneEdge[i] = chkGap[i] ? cyc : -1;
                    end
                    if (!chkGap[i]) doneEdge[i] = -1;
                    if (xmitH[i]) begin
                        chk($sformatf("m%0d_launch_after_done", i), int'(inFlight[i]), 0);
                        have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
                        chk($sformatf("m%0d_expected_launch", i), int'(have), 1);
                        if (have) begin
                            if (i == 0) expB = q0.pop_front();
                            else expB = q1.pop_front();
                            chk($sformatf("m%0d_data", i), int'(xmitData[i]), int'(expB));
                        end
                        if (doneEdge[i] >= 0) begin
                            chk($sformatf("m%0d_done_to_launch", i), cyc - doneEdge[i],
                                ((i == 0) ? G0 : G1) + 1);
                        end
                        inFlight[i] = 1'b1;
                        doneEdge[i] = -1;
                    end
                    prevX[i] = xmitH[i];
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        sys_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wrEn[i]     = 1'b0;
            wrData[i]   = 8'h00;
            autoDone[i] = 1'b0;
            randDly[i]  = 1'b0;
            chkGap[i]   = 1'b0;
            fixDly[i]   = 4;
            pulseReq[i] = 0;
        end
        nedge(3);
        chkReset("rst");
        sys_rst = 1'b0;
        nedge(2);

        // Single byte, no gap; second byte pushed in the pop cycle; spurious dones.
        wrEn[0] = 1'b1; wrData[0] = 8'hA5; q0.push_back(8'hA5);
        nedge(1);
        chk("A_lvl_after_push", int'(lvl0), 1);
        chk("A_not_empty", int'(empty[0]), 0);
        chk("A_no_early_launch", int'(xmitH[0]), 0);
        wrData[0] = 8'h5A; q0.push_back(8'h5A);
        nedge(1);
        wrEn[0] = 1'b0;
        chk("A_launch", int'(xmitH[0]), 1);
        chk("A_data", int'(xmitData[0]), 'hA5);
        chk("A_lvl_push_pop", int'(lvl0), 1);
        pulseDone(0);
        nedge(1);
        chk("A_strobe_one_cycle", int'(xmitH[0]), 0);
        nedge(3);
        chk("A_still_queued", int'(lvl0), 1);
        chk("A_data_hold", int'(xmitData[0]), 'hA5);
        pulseDone(0);
        nedge(1);
        chk("A_no_launch_at_done", int'(xmitH[0]), 0);
        nedge(1);
        chk("A_launch2", int'(xmitH[0]), 1);
        chk("A_data2", int'(xmitData[0]), 'h5A);
        chk("A_lvl_drained", int'(lvl0), 0);
        pulseDone(0);
        nedge(1);
        pulseDone(0);
        nedge(2);
        chk("A_empty_after", int'(empty[0]), 1);
        pulseDone(0);
        nedge(3);
        chk("A_idle_spurious", int'(xmitH[0]), 0);

        // Reset in the middle of a frame with bytes still queued.
        wrEn[0] = 1'b1; wrData[0] = 8'h11; q0.push_back(8'h11);
        nedge(1); wrData[0] = 8'h22; q0.push_back(8'h22);
        nedge(1); wrData[0] = 8'h33; q0.push_back(8'h33);
        nedge(1); wrEn[0] = 1'b0;
        chk("B_lvl_before_rst", int'(lvl0), 2);
        nedge(1);
        sys_rst = 1'b1;
        nedge(1);
        chkReset("B_rst");
        nedge(1);
        sys_rst = 1'b0;
        pulseDone(0);
        nedge(5);
        chk("B_no_launch_after_rst", int'(xmitH[0]), 0);
        chk("B_empty_after_rst", int'(empty[0]), 1);
        wrEn[0] = 1'b1; wrData[0] = 8'h44; q0.push_back(8'h44);
        nedge(1); wrEn[0] = 1'b0;
        nedge(1);
        chk("B_relaunch", int'(xmitH[0]), 1);
        nedge(1);
        pulseDone(0);
        nedge(2);

        // Wrap-around with random done delays.
        autoDone[0] = 1'b1; randDly[0] = 1'b1; chkGap[0] = 1'b1;
        for (int b = 0; b < 2 * D0 + 3; b++) begin
            int guard = 0;
            while (full[0] && guard < 200) begin
                nedge(1);
                guard++;
            end
            wrEn[0] = 1'b1; wrData[0] = 8'(b); q0.push_back(8'(b));
            nedge(1);
            wrEn[0] = 1'b0;
            chk("C_level_bound", int'(int'(lvl0) <= D0), 1);
        end
        waitDrain(0, 3000);
        nedge(10);
        autoDone[0] = 1'b0; randDly[0] = 1'b0; chkGap[0] = 1'b0;
        chk("C_level_end", int'(lvl0), 0);

        // Burst ordering with a gap of 2.
        autoDone[1] = 1'b1; fixDly[1] = 4; chkGap[1] = 1'b1;
        wrEn[1] = 1'b1; wrData[1] = 8'h01; q1.push_back(8'h01);
        nedge(1); wrData[1] = 8'h02; q1.push_back(8'h02);
        nedge(1); wrData[1] = 8'h03; q1.push_back(8'h03);
        nedge(1); wrEn[1] = 1'b0;
        waitDrain(1, 500);
        nedge(10);
        autoDone[1] = 1'b0;

        // Spurious dones during the gap must not disturb it.
        clearGap(1);
        wrEn[1] = 1'b1; wrData[1] = 8'hAA; q1.push_back(8'hAA);
        nedge(1); wrData[1] = 8'hBB; q1.push_back(8'hBB);
        nedge(1); wrEn[1] = 1'b0;
        chk("E_launch_AA", int'(xmitH[1]), 1);
        nedge(1); pulseDone(1);
        nedge(1); pulseDone(1);
        nedge(1); pulseDone(1);
        nedge(1);
        chk("E_gap_no_launch", int'(xmitH[1]), 0);
        nedge(1);
        chk("E_launch_BB", int'(xmitH[1]), 1);
        chk("E_data_BB", int'(xmitData[1]), 'hBB);
        nedge(1); pulseDone(1);
        nedge(6);

        // Fill to full with the UART held busy, then overflow twice.
        clearGap(1);
        wrEn[1] = 1'b1; wrData[1] = 8'hC0; q1.push_back(8'hC0);
        nedge(1); wrEn[1] = 1'b0;
        nedge(1);
        chk("F_launch_C0", int'(xmitH[1]), 1);
        for (int j = 1; j <= 5; j++) begin
            wrEn[1] = 1'b1; wrData[1] = 8'(8'hC0 + j);
            if (j <= 4) q1.push_back(8'(8'hC0 + j));
            nedge(1);
            chk($sformatf("F_level_%0d", j), int'(lvl1), (j < 4) ? j : 4);
            chk($sformatf("F_full_%0d", j), int'(full[1]), int'(j >= 4));
            chk($sformatf("F_ovf_%0d", j), int'(overflow[1]), int'(j == 5));
        end
        wrEn[1] = 1'b0;
        nedge(1);
        chk("F_ovf_one_cycle", int'(overflow[1]), 0);
        chk("F_level_after_drop", int'(lvl1), 4);
        wrEn[1] = 1'b1; wrData[1] = 8'hEE;
        pulseDone(1);
        nedge(1);
        wrEn[1] = 1'b0;
        chk("F_ovf_at_done", int'(overflow[1]), 1);
        chk("F_level_at_done", int'(lvl1), 4);
        nedge(2);
        chk("F_gap_quiet", int'(xmitH[1]), 0);
        nedge(1);
        chk("F_launch_C1", int'(xmitH[1]), 1);
        chk("F_data_C1", int'(xmitData[1]), 'hC1);
        chk("F_level_C1", int'(lvl1), 3);
        autoDone[1] = 1'b1;
        waitDrain(1, 500);
        nedge(12);
        chk("F_empty_end", int'(empty[1]), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
